interrupt_acknowledge_initiator: RTL

//  CPU-side initiator of the 8259A INTA protocol. On interrupt_to_cpu it drives an active-low

---
 rtl/interrupt_acknowledge_initiator.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/interrupt_acknowledge_initiator.sv
// CPU-side 8259A INTA initiator: pulse train, bus capture, vector handshake.
// Define INTA_OPCODE_CHECK_EN to flag MCS-80 opcodes other than CALL (CDh).
module interrupt_acknowledge_initiator #(
  parameter int INTA_LOW_CYCLES = 2,
  parameter int INTA_GAP_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        interrupt_to_cpu,
  input  logic        interrupt_enable,
  input  logic        u8086_or_mcs80_config,
  input  logic [7:0]  data_bus_in,
  output logic        interrupt_acknowledge_n,
  output logic        busy,
  output logic        vector_valid,
  input  logic        vector_ready,
  output logic [7:0]  vector_type,
  output logic [7:0]  call_opcode,
  output logic [15:0] call_address,
  output logic        opcode_error
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] PULSE_LOW = 2'd1;
  localparam logic [1:0] PULSE_GAP = 2'd2;
  localparam logic [1:0] PRESENT   = 2'd3;

  localparam int MAXC =
    (INTA_LOW_CYCLES > INTA_GAP_CYCLES) ?
    INTA_LOW_CYCLES : INTA_GAP_CYCLES;
  localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] LOW_LAST =
    CW'(INTA_LOW_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST =
    CW'(INTA_GAP_CYCLES - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [1:0]    pulse_count;
  logic          mode_8086;
  logic          inta_n_q;
  logic [7:0]    byte0;
  logic [7:0]    byte1;
  logic          last_pulse;
  logic          low_done;
  logic          gap_done;
  logic          accept;

  assign last_pulse = mode_8086 ?
    (pulse_count == 2'd1) : (pulse_count == 2'd2);
  assign low_done = (state == PULSE_LOW) && (cnt == LOW_LAST);
  assign gap_done = (state == PULSE_GAP) && (cnt == GAP_LAST);
  assign accept   = (state == PRESENT) && vector_ready;

  assign interrupt_acknowledge_n = inta_n_q;
  assign busy         = (state != IDLE);
  assign vector_valid = (state == PRESENT);

  // Sequencer: start on enabled INT, time low/gap phases, hold until accepted.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      pulse_count <= 2'd0;
      mode_8086   <= 1'b0;
      inta_n_q    <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (interrupt_to_cpu && interrupt_enable) begin
            state       <= PULSE_LOW;
            inta_n_q    <= 1'b0;
            mode_8086   <= u8086_or_mcs80_config;
            pulse_count <= 2'd0;
            cnt         <= '0;
          end
        end
        PULSE_LOW: begin
          if (low_done) begin
            cnt         <= '0;
            pulse_count <= pulse_count + 2'd1;
            inta_n_q    <= 1'b1;
            state       <= last_pulse ? PRESENT : PULSE_GAP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        PULSE_GAP: begin
          if (gap_done) begin
            cnt      <= '0;
            inta_n_q <= 1'b0;
            state    <= PULSE_LOW;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        PRESENT: begin
          if (accept) begin
            state <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          inta_n_q <= 1'b1;
        end
      endcase
    end
  end

  // Capture the PIC bus on the last low cycle of the first two pulses.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      byte0 <= 8'h00;
      byte1 <= 8'h00;
    end else if (low_done) begin
      if (pulse_count == 2'd0) byte0 <= data_bus_in;
      if (pulse_count == 2'd1) byte1 <= data_bus_in;
    end
  end

  // Load the presented vector when the final byte arrives; retain after accept.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      vector_type  <= 8'h00;
      call_opcode  <= 8'h00;
      call_address <= 16'h0000;
    end else if (low_done && last_pulse) begin
      if (mode_8086) begin
        vector_type  <= data_bus_in;
        call_opcode  <= 8'h00;
        call_address <= 16'h0000;
      end else begin
        vector_type  <= 8'h00;
        call_opcode  <= byte0;
        call_address <= {data_bus_in, byte1};
      end
    end
  end

`ifdef INTA_OPCODE_CHECK_EN
  // Flag a non-CALL MCS-80 opcode alongside the vector; clear on accept.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      opcode_error <= 1'b0;
    end else if (low_done && last_pulse) begin
      opcode_error <= !mode_8086 && (byte0 != 8'hCD);
    end else if (accept) begin
      opcode_error <= 1'b0;
    end
  end
`else
  assign opcode_error = 1'b0;
`endif

endmodule
